// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word addresses to a 1-cycle
// registered instruction memory, buffers returned words in a 2-entry FIFO and
// hands them to decode over valid/ready. Supports branch redirect with flush
// and a sticky out-of-range fetch fault.
// Optional: define IFU_PERF_COUNTERS_EN to add fetch_count/flush_count outputs.
module instruction_fetch_unit #(
    parameter int           n        = 64,
    parameter int           DEPTH    = 1024,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [n-1:0] read_address,
    input  logic [n-1:0] mem_data,
    input  logic         branch_taken,
    input  logic [n-1:0] branch_target,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [n-1:0] inst_out,
    output logic [n-1:0] inst_pc,
    output logic         fetch_fault
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  flush_count
`endif
);

    localparam logic [n-1:0] L_DEPTH = n'(DEPTH);
    localparam logic [n-1:0] L_ONE   = n'(1);

    logic [n-1:0] r_pc;
    logic         r_inflight;
    logic [n-1:0] r_inflight_pc;
    logic [n-1:0] r_buf_word [2];
    logic [n-1:0] r_buf_pc   [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         r_fault;

    logic         w_pop;
    logic         w_push;
    logic [1:0]   w_occ;
    logic         w_in_range;
    logic         w_can_fetch;
    logic         w_issue;
    logic         w_fault_set;

    // Handshake, credit and issue/fault decisions for this cycle
    always_comb begin
        w_pop       = (r_count != 2'd0) && inst_ready;
        w_push      = r_inflight && !branch_taken;
        // Slots committed after this edge: buffered minus leaving plus returning
        w_occ       = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
        w_in_range  = (r_pc < L_DEPTH);
        w_can_fetch = !branch_taken && !r_fault && (w_occ < 2'd2);
        w_issue     = w_can_fetch && w_in_range;
        w_fault_set = w_can_fetch && !w_in_range;
    end

    // PC, inflight tracking, FIFO pointers/count and fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_fault       <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (branch_taken) begin
                // Redirect drops everything buffered or in flight
                r_pc     <= branch_target;
                r_fault  <= 1'b0;
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + L_ONE;
                end
                if (w_fault_set) begin
                    r_fault <= 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // FIFO storage; contents are only observed while r_count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_word[r_wr_ptr] <= mem_data;
            r_buf_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    // Output drive: head of FIFO, zeroed when empty
    always_comb begin
        read_address = r_pc;
        inst_valid   = (r_count != 2'd0);
        inst_out     = '0;
        inst_pc      = '0;
        if (inst_valid) begin
            inst_out = r_buf_word[r_rd_ptr];
            inst_pc  = r_buf_pc[r_rd_ptr];
        end
        fetch_fault  = r_fault;
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    // Count buffer pushes and redirect cycles, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (w_push) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (branch_taken) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    // Expose counters
    always_comb begin
        fetch_count = r_fetch_count;
        flush_count = r_flush_count;
    end
`endif

endmodule
